ic_line_array: RTL and testbench



---
 rtl/ic_pkg.sv | 12 +
 rtl/tag_eq6.sv | 14 +
 rtl/ic_line_array.sv | 70 +++++++
 tb/tb_ic_line_array.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ic_pkg.sv
// Shared instruction-cache constants and line/tag types.
package ic_pkg;

    localparam int IC_LINE_BYTES  = 32;
    localparam int IC_TAG_W       = 6;
    localparam int IC_ARRAY_DEPTH = 8;
    localparam int IC_IDX_W       = 3;

    typedef logic [8*IC_LINE_BYTES-1:0] ic_line_t;
    typedef logic [IC_TAG_W-1:0]        ic_tag_t;

endpackage

// File: rtl/tag_eq6.sv
// Equality comparator for instruction-cache tags.
import ic_pkg::*;

module tag_eq6 #(
    parameter int W = IC_TAG_W
) (
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    output logic         eq_out
);

    assign eq_out = (in1 == in2);

endmodule

// File: rtl/ic_line_array.sv
// Eight-entry I-cache line array: fill writes, combinational indexed read and tag compare.
// Optional same-cycle write-to-read forwarding under `IC_LINE_ARRAY_BYPASS_EN.
import ic_pkg::*;

module ic_line_array #(
    parameter int LINE_BYTES = IC_LINE_BYTES,
    parameter int TAG_W      = IC_TAG_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [IC_IDX_W-1:0]     addr,
    input  logic                    oe_n,
    input  logic                    wr_en,
    input  logic [8*LINE_BYTES-1:0] wr_data,
    input  logic [TAG_W-1:0]        wr_tag,
    input  logic [TAG_W-1:0]        cmp_tag,
    output logic [8*LINE_BYTES-1:0] rd_data,
    output logic [TAG_W-1:0]        rd_tag,
    output logic                    rd_valid,
    output logic                    tag_eq,
    output logic                    hit
);

    logic [8*LINE_BYTES-1:0]   r_data [IC_ARRAY_DEPTH];
    logic [TAG_W-1:0]          r_tag  [IC_ARRAY_DEPTH];
    logic [IC_ARRAY_DEPTH-1:0] r_valid;

    logic [8*LINE_BYTES-1:0]   w_line;
    logic [TAG_W-1:0]          w_tag;
    logic                      w_valid;
    logic                      w_tag_eq;

    // Only valid bits are reset; a fill coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (wr_en) begin
            r_data[addr]  <= wr_data;
            r_tag[addr]   <= wr_tag;
            r_valid[addr] <= 1'b1;
        end
    end

    always_comb begin
        w_line  = r_data[addr];
        w_tag   = r_tag[addr];
        w_valid = r_valid[addr];
`ifdef IC_LINE_ARRAY_BYPASS_EN
        // Read and write share addr, so any accepted fill targets the entry being read.
        if (wr_en && !rst) begin
            w_line  = wr_data;
            w_tag   = wr_tag;
            w_valid = 1'b1;
        end
`endif
    end

    tag_eq6 #(.W(TAG_W)) u_tag_eq (
        .in1    (w_tag),
        .in2    (cmp_tag),
        .eq_out (w_tag_eq)
    );

    assign rd_data  = oe_n ? '0 : w_line;
    assign rd_tag   = w_tag;
    assign rd_valid = w_valid;
    assign tag_eq   = w_tag_eq;
    assign hit      = w_tag_eq & w_valid;

endmodule

// File: tb/tb_ic_line_array.sv
// Self-checking bench for ic_line_array: directed scenarios plus randomized traffic vs. an array model.
module tb_ic_line_array;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   addr;
    logic         oe_n;
    logic         wr_en;
    logic [255:0] wr_data;
    logic [5:0]   wr_tag;
    logic [5:0]   cmp_tag;
    logic [255:0] rd_data;
    logic [5:0]   rd_tag;
    logic         rd_valid;
    logic         tag_eq;
    logic         hit;

    int checks   = 0;
    int failures = 0;

    // Reference model: plain arrays updated with the fill/reset rules.
    logic [255:0] m_data    [8];
    logic [5:0]   m_tag     [8];
    bit           m_valid   [8];
    bit           m_written [8];

`ifdef IC_LINE_ARRAY_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    ic_line_array #(.LINE_BYTES(32), .TAG_W(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .oe_n     (oe_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .wr_tag   (wr_tag),
        .cmp_tag  (cmp_tag),
        .rd_data  (rd_data),
        .rd_tag   (rd_tag),
        .rd_valid (rd_valid),
        .tag_eq   (tag_eq),
        .hit      (hit)
    );

    always #5 clk = ~clk;

    task automatic tick();
        if (rst) begin
            for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        end else if (wr_en) begin
            m_data[addr]    = wr_data;
            m_tag[addr]     = wr_tag;
            m_valid[addr]   = 1'b1;
            m_written[addr] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; oe_n = 1'b0; addr = '0;
        wr_data = '0; wr_tag = '0; cmp_tag = '0;
        tick();
        tick();
        rst = 1'b0;
        for (int a = 0; a < 8; a++) begin
            addr = a[2:0];
            #1;
            checks++;
            if (rd_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_valid addr=%0d got=%b exp=0", a, rd_valid);
            end
            checks++;
            if (hit !== 1'b0) begin
                failures++;
                $display("FAIL reset_hit addr=%0d got=%b exp=0", a, hit);
            end
        end
    endtask

    task automatic test_fill_hit();
        logic [255:0] line;
        line = {8{32'hDEADBEEF}};
        addr = 3'd5; wr_en = 1'b1; wr_tag = 6'h2A; wr_data = line;
        tick();
        wr_en = 1'b0; cmp_tag = 6'h2A; wr_data = '0;
        #1;
        checks++;
        if (rd_data !== line) begin
            failures++;
            $display("FAIL fill_data got=%h exp=%h", rd_data, line);
        end
        checks++;
        if (tag_eq !== 1'b1) begin
            failures++;
            $display("FAIL fill_tag_eq got=%b exp=1", tag_eq);
        end
        checks++;
        if (hit !== 1'b1) begin
            failures++;
            $display("FAIL fill_hit got=%b exp=1", hit);
        end
        addr = 3'd4;
        #1;
        checks++;
        if (hit !== 1'b0) begin
            failures++;
            $display("FAIL other_entry_hit got=%b exp=0", hit);
        end
    endtask

    task automatic test_miss_and_oe();
        addr = 3'd5; cmp_tag = 6'h2B;
        #1;
        checks++;
        if (tag_eq !== 1'b0 || hit !== 1'b0) begin
            failures++;
            $display("FAIL tag_miss got tag_eq=%b hit=%b exp 0/0", tag_eq, hit);
        end
        oe_n = 1'b1;
        #1;
        checks++;
        if (rd_data !== '0) begin
            failures++;
            $display("FAIL oe_gate_data got=%h exp=0", rd_data);
        end
        checks++;
        if (rd_valid !== 1'b1 || rd_tag !== 6'h2A) begin
            failures++;
            $display("FAIL oe_ungated got valid=%b tag=%h exp 1/2a", rd_valid, rd_tag);
        end
        oe_n = 1'b0;
    endtask

    task automatic test_back_to_back();
        addr = 3'd3; wr_en = 1'b1; wr_tag = 6'h11; wr_data = {8{32'h11111111}};
        tick();
        wr_tag = 6'h22; wr_data = {8{32'h22222222}};
        tick();
        wr_en = 1'b0; cmp_tag = 6'h11;
        #1;
        checks++;
        if (rd_tag !== 6'h22) begin
            failures++;
            $display("FAIL refill_tag got=%h exp=22", rd_tag);
        end
        checks++;
        if (hit !== 1'b0) begin
            failures++;
            $display("FAIL refill_old_tag_hit got=%b exp=0", hit);
        end
        checks++;
        if (rd_data !== {8{32'h22222222}}) begin
            failures++;
            $display("FAIL refill_data got=%h exp=%h", rd_data, {8{32'h22222222}});
        end
    endtask

    task automatic test_reset_priority();
        addr = 3'd0; rst = 1'b1; wr_en = 1'b1; wr_tag = 6'h05; wr_data = '1;
        tick();
        rst = 1'b0; wr_en = 1'b0; cmp_tag = 6'h05;
        #1;
        checks++;
        if (rd_valid !== 1'b0 || hit !== 1'b0) begin
            failures++;
            $display("FAIL rst_over_fill got valid=%b hit=%b exp 0/0", rd_valid, hit);
        end
        addr = 3'd5; cmp_tag = 6'h2A;
        #1;
        checks++;
        if (hit !== 1'b0) begin
            failures++;
            $display("FAIL rst_clears_entry5 got hit=%b exp=0", hit);
        end
    endtask

    task automatic test_same_cycle();
        addr = 3'd7; wr_en = 1'b1; wr_tag = 6'h3F; cmp_tag = 6'h3F;
        wr_data = {8{32'hCAFEF00D}};
        #1;
        checks++;
        if (hit !== BYPASS) begin
            failures++;
            $display("FAIL same_cycle_hit got=%b exp=%b", hit, BYPASS);
        end
        checks++;
        if (rd_valid !== BYPASS) begin
            failures++;
            $display("FAIL same_cycle_valid got=%b exp=%b", rd_valid, BYPASS);
        end
        tick();
        wr_en = 1'b0;
        #1;
        checks++;
        if (hit !== 1'b1 || rd_data !== {8{32'hCAFEF00D}}) begin
            failures++;
            $display("FAIL after_fill7 got hit=%b data=%h", hit, rd_data);
        end
    endtask

    task automatic test_random();
        logic         e_valid;
        logic [5:0]   e_tag;
        logic [255:0] e_data;
        bit           known;
        for (int n = 0; n < 400; n++) begin
            addr  = 3'($urandom_range(0, 7));
            wr_en = ($urandom_range(0, 99) < 35);
            rst   = ($urandom_range(0, 99) < 3);
            oe_n  = ($urandom_range(0, 99) < 20);
            wr_tag = 6'($urandom);
            for (int k = 0; k < 8; k++) wr_data[k*32 +: 32] = $urandom;
            if (m_written[addr] && $urandom_range(0, 1) == 1) cmp_tag = m_tag[addr];
            else cmp_tag = 6'($urandom);
            #1;
            if (BYPASS && wr_en && !rst) begin
                e_valid = 1'b1; e_tag = wr_tag; e_data = wr_data; known = 1'b1;
            end else begin
                e_valid = m_valid[addr]; e_tag = m_tag[addr];
                e_data = m_data[addr]; known = m_written[addr];
            end
            checks++;
            if (rd_valid !== e_valid || hit !== (e_valid && known && e_tag == cmp_tag)) begin
                failures++;
                $display("FAIL rand_valid_hit n=%0d addr=%0d got v=%b h=%b exp v=%b h=%b",
                         n, addr, rd_valid, hit, e_valid, e_valid && known && e_tag == cmp_tag);
            end
            if (known) begin
                checks++;
                if (rd_tag !== e_tag || tag_eq !== (e_tag == cmp_tag)) begin
                    failures++;
                    $display("FAIL rand_tag n=%0d got tag=%h eq=%b exp tag=%h eq=%b",
                             n, rd_tag, tag_eq, e_tag, e_tag == cmp_tag);
                end
                checks++;
                if (rd_data !== (oe_n ? 256'd0 : e_data)) begin
                    failures++;
                    $display("FAIL rand_data n=%0d addr=%0d oe_n=%b got=%h", n, addr, oe_n, rd_data);
                end
            end else if (oe_n) begin
                checks++;
                if (rd_data !== '0) begin
                    failures++;
                    $display("FAIL rand_gate_unwritten n=%0d got=%h exp=0", n, rd_data);
                end
            end
            tick();
        end
        rst = 1'b0; wr_en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_written[i] = 1'b0;
            m_data[i] = '0;
            m_tag[i] = '0;
        end
        test_reset();
        test_fill_hit();
        test_miss_and_oe();
        test_back_to_back();
        test_reset_priority();
        test_same_cycle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
